// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked 2-entry skid pipeline register with flush
// Optional performance counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int DATA_W        = 165,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              drain;

  // in_ready depends only on the skid flop, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occ       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign accept = in_valid & ~skid_valid_q;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (ZERO_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (skid_valid_q) begin
      if (drain) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && drain) begin
        main_data_d = in_data;
      end else if (accept) begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      main_data_d  = in_data;
      main_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush deliberately leaves them alone
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!main_valid_q && out_ready && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboard checks for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DATA_W = 165;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_q[$];

  pipe_stage_reg #(.DATA_W(DATA_W), .ZERO_ON_FLUSH(1'b1), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occ        (occ),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occ", occ, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);

    // streaming 1..8
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DATA_W'(k), 1'b1);
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data", out_data, k);
      check("stream_occ", occ, 1);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    check("stream_drained", out_valid, 0);
    check("stream_drained_occ", occ, 0);

    // backpressure
    drive(1'b1, 'hA, 1'b1);
    tick();
    check("bp_a_out", out_data, 'hA);
    drive(1'b1, 'hB, 1'b0);
    check("bp_b_in_ready", in_ready, 1);
    tick();
    check("bp_full_occ", occ, 2);
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_data", out_data, 'hA);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 'hC, 1'b0);
      tick();
      check("bp_hold_occ", occ, 2);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_data", out_data, 'hA);
      check("bp_hold_valid", out_valid, 1);
    end
    drive(1'b1, 'hC, 1'b1);
    tick();
    check("bp_rel_b", out_data, 'hB);
    check("bp_rel_occ", occ, 1);
    check("bp_rel_in_ready", in_ready, 1);
    drive(1'b1, 'hC, 1'b1);
    tick();
    check("bp_rel_c", out_data, 'hC);
    check("bp_rel_c_valid", out_valid, 1);
    drive(1'b0, '0, 1'b1);
    tick();
    check("bp_empty", out_valid, 0);

    // flush while FULL
    drive(1'b1, 'h11, 1'b0);
    tick();
    drive(1'b1, 'h22, 1'b0);
    tick();
    check("fl_full_occ", occ, 2);
    flush = 1'b1;
    drive(1'b1, 'h55, 1'b0);
    tick();
    flush = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_occ", occ, 0);
    check("fl_out_data", out_data, 0);
    check("fl_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1);
      tick();
      check("fl_no_55", out_valid, 0);
    end

    // async reset mid-stream
    drive(1'b1, 'h31, 1'b0);
    tick();
    drive(1'b1, 'h32, 1'b0);
    tick();
    check("ar_full_occ", occ, 2);
    drive(1'b0, '0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_occ", occ, 0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 'h40, 1'b1);
    tick();
    check("ar_first_valid", out_valid, 1);
    check("ar_first_data", out_data, 'h40);
    drive(1'b0, '0, 1'b1);
    tick();

    // perf counters: 5 stall cycles then 3 bubble cycles
    do_reset();
    drive(1'b1, 'h60, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    drive(1'b0, '0, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) tick();
    drive(1'b0, '0, 1'b0);
    tick();
`ifdef PIPE_STAGE_PERF_EN
    check("perf_stall", stall_cnt, 5);
    check("perf_bubble", bubble_cnt, 3);
`else
    check("perf_stall_off", stall_cnt, 0);
    check("perf_bubble_off", bubble_cnt, 0);
`endif

    // random traffic against a queue scoreboard
    model_q.delete();
    for (int i = 0; i < 3000; i++) begin
      logic acc;
      logic drn;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = DATA_W'(32'h1000 + i);
      check("rnd_in_ready", in_ready, (model_q.size() < 2));
      acc = in_valid && (model_q.size() < 2);
      drn = out_ready && (model_q.size() > 0);
      tick();
      if (flush) begin
        model_q.delete();
      end else begin
        if (drn) void'(model_q.pop_front());
        if (acc) model_q.push_back(in_data);
      end
      check("rnd_occ", occ, model_q.size());
      check("rnd_out_valid", out_valid, (model_q.size() > 0));
      if (model_q.size() > 0) check("rnd_out_data", out_data, model_q[0]);
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
